// File: rtl/score_tracker.sv
// score_tracker: N-hole hit scorer with combo multiplier and BCD score drain.
// Optional SCORE_PENALTY_EN: each miss pulse also takes one BCD unit off the score.
`ifndef POP
`define POP 2'b01
`endif
`ifndef HIT
`define HIT 2'b10
`endif

module score_tracker #(
   parameter int N_HOLES    = 10,
   parameter int DIGITS     = 4,
   parameter int HIT_PTS    = 1,
   parameter int COMBO_STEP = 4,
   parameter int MULT_MAX   = 4,
   parameter int PEND_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic [1:0]            state,
   input  logic [N_HOLES-1:0]    hamster_op,
   input  logic [N_HOLES-1:0]    hit,
   output logic                  add_score,
   output logic                  miss,
   output logic [7:0]            combo,
   output logic [4*DIGITS-1:0]   score,
   output logic                  busy
);

   localparam int SW = 4 * DIGITS;
   localparam logic [31:0] PMAX = 32'((64'd1 << PEND_W) - 64'd1);
   localparam logic [SW-1:0] ALL9 = {DIGITS{4'h9}};

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRAIN = 2'd1;
   localparam logic [1:0] SAT   = 2'd2;

   logic [1:0]         fsm, fsm_nxt;
   logic [PEND_W-1:0]  pending, pend_nxt;
   logic [N_HOLES-1:0] good, bad;
   logic [15:0]        ng;
   logic [31:0]        mult, pts, combo_sum, pend_sum;
   logic [7:0]         combo_nxt;
   logic [SW-1:0]      score_inc, score_dec, score_nxt;
   logic               dec, drain;

   function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [SW-1:0] bcd_dec(input logic [SW-1:0] v);
      logic [SW-1:0] r;
      logic          b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      good = (state == `POP) ? (hit & hamster_op) : '0;
      bad  = (state == `POP) ? (hit & ~hamster_op) : '0;
      ng   = '0;
      for (int i = 0; i < N_HOLES; i++) begin
         ng = ng + 16'(good[i]);
      end
      // multiplier is taken from the combo before this cycle's update
      mult = 32'(combo) / COMBO_STEP + 32'd1;
      if (mult > 32'(MULT_MAX)) begin
         mult = 32'(MULT_MAX);
      end
      pts       = 32'(ng) * 32'(HIT_PTS) * mult;
      combo_sum = 32'(combo) + 32'(ng);
      if (bad != '0) begin
         combo_nxt = 8'd0;
      end else if (combo_sum > 32'd255) begin
         combo_nxt = 8'd255;
      end else begin
         combo_nxt = combo_sum[7:0];
      end
`ifdef SCORE_PENALTY_EN
      dec = miss && (fsm != SAT);
`else
      dec = 1'b0;
`endif
      // a penalty cycle defers the drain step rather than dropping it
      drain     = (fsm == DRAIN) && !dec;
      score_inc = bcd_inc(score);
      score_dec = bcd_dec(score);
      score_nxt = score;
      if (dec) begin
         if (score != '0) begin
            score_nxt = score_dec;
         end
      end else if (drain) begin
         score_nxt = score_inc;
      end
      pend_sum = 32'(pending) - 32'(drain) + pts;
      if (pend_sum > PMAX) begin
         pend_nxt = PMAX[PEND_W-1:0];
      end else begin
         pend_nxt = pend_sum[PEND_W-1:0];
      end
      fsm_nxt = fsm;
      unique case (fsm)
         SAT: begin
            fsm_nxt  = SAT;
            pend_nxt = '0;
         end
         default: begin
            if (drain && (score_inc == ALL9)) begin
               fsm_nxt  = SAT;
               pend_nxt = '0;
            end else begin
               fsm_nxt = (pend_nxt != '0) ? DRAIN : IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         add_score <= 1'b0;
         miss      <= 1'b0;
         combo     <= '0;
         score     <= '0;
         pending   <= '0;
         fsm       <= IDLE;
      end else if (clear) begin
         add_score <= 1'b0;
         miss      <= 1'b0;
         combo     <= '0;
         score     <= '0;
         pending   <= '0;
         fsm       <= IDLE;
      end else begin
         add_score <= (ng != '0);
         miss      <= (bad != '0);
         combo     <= combo_nxt;
         score     <= score_nxt;
         pending   <= pend_nxt;
         fsm       <= fsm_nxt;
      end
   end

   assign busy = (fsm == DRAIN);

endmodule
